// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the clocks-per-bit
// helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } rx_state_t;

  // Number of system clocks per serial bit; callers keep the result >= 4 so
  // the half-bit start offset stays meaningful.
  function automatic int uart_scale(input int clk_mhz, input int boadrate);
    return (clk_mhz * 1000000) / boadrate;
  endfunction

endpackage

// File: rtl/uart_rx_reader_if.sv
// Byte delivery handshake between the UART receiver and its consumer.
// The receiver is the master (drives valid/data), the consumer the slave.
interface uart_rx_reader_if;

  logic       valid;
  logic       ready;
  logic [7:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx pin. Resets to the idle
// line level (1) so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic arstn,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw pin through two flops to settle metastability.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_reader.sv
// 8N1 UART receiver, LSB first. Samples each bit at mid-period using a
// down-counter started half a bit after the synchronized falling edge, then
// hands complete bytes to a single holding register behind valid/ready.
// Stop bit low gives a frame_err pulse; a byte that finds the holding
// register still occupied gives an overrun pulse and is discarded.
module uart_rx_reader
  import uart_pkg::*;
#(
  parameter int clk_mhz  = 50,
  parameter int boadrate = 9600
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              rx,
  uart_rx_reader_if.master  rx_if,
  output logic              frame_err,
  output logic              overrun
);

  localparam int          SCALE       = uart_scale(clk_mhz, boadrate);
  localparam logic [31:0] BIT_RELOAD  = 32'(SCALE - 1);
  localparam logic [31:0] HALF_RELOAD = 32'(SCALE / 2 - 1);

  logic        rx_s;
  rx_state_t   state;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        valid_q;
  logic [7:0]  data_q;
  logic        sample;
  logic        take;

  uart_rx_sync u_sync (
    .clk   (clk),
    .arstn (arstn),
    .d     (rx),
    .q     (rx_s)
  );

  assign sample      = (cnt == 32'd0);
  assign take        = valid_q && rx_if.ready;
  assign rx_if.valid = valid_q;
  assign rx_if.data  = data_q;

  // Frame FSM, bit timing, shift register and holding register in one place
  // so that delivery, overrun and consumption resolve in the same cycle.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state     <= IDLE;
      cnt       <= 32'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      valid_q   <= 1'b0;
      data_q    <= 8'd0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (take) begin
        valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_RELOAD;
            state <= START;
          end
        end
        START: begin
          if (sample) begin
            cnt <= BIT_RELOAD;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        DATA: begin
          if (sample) begin
            cnt     <= BIT_RELOAD;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        STOP: begin
          if (sample) begin
            cnt <= BIT_RELOAD;
            if (rx_s) begin
              state <= IDLE;
              if (!valid_q || take) begin
                valid_q <= 1'b1;
                data_q  <= shreg;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HI;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        WAIT_HI: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_reader.sv
// Testbench for uart_rx_reader at scale=10: single frame with latency,
// start glitch, framing error, overrun, mid-frame reset and a random
// back-to-back stream with random ready stalls.
module tb_uart_rx_reader;
  import uart_pkg::*;

  localparam int CLK_MHZ  = 1;
  localparam int BOADRATE = 100000;
  localparam int SCALE    = 10;

  logic clk   = 1'b0;
  logic arstn = 1'b1;
  logic rx    = 1'b1;
  logic frame_err;
  logic overrun;

  uart_rx_reader_if rx_if ();

  uart_rx_reader #(
    .clk_mhz  (CLK_MHZ),
    .boadrate (BOADRATE)
  ) dut (
    .clk       (clk),
    .arstn     (arstn),
    .rx        (rx),
    .rx_if     (rx_if.master),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         cycle = 0;
  int         frame_err_cnt = 0;
  int         overrun_cnt = 0;
  int         valid_high_cnt = 0;
  int         valid_rise_cycle = 0;
  logic       prev_valid = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;

  // Count comparisons and report any mismatch.
  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Free-running cycle count used for latency measurement.
  always @(posedge clk) cycle++;

  // Output monitor: scoreboard pops, pulse counting and hold stability.
  always @(negedge clk) begin
    if (!arstn) begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (frame_err) frame_err_cnt++;
      if (overrun) overrun_cnt++;
      if (rx_if.valid) valid_high_cnt++;
      if (rx_if.valid && !prev_valid) valid_rise_cycle = cycle;
      if (prev_hold) begin
        check_output("hold_valid", {31'd0, rx_if.valid}, 32'd1);
        check_output("hold_data", {24'd0, rx_if.data}, {24'd0, prev_data});
      end
      if (rx_if.valid && rx_if.ready) begin
        if (exp_q.size() == 0)
          check_output("unexpected_byte", {24'd0, rx_if.data}, 32'hFFFF_FFFF);
        else
          check_output("rx_byte", {24'd0, rx_if.data}, {24'd0, exp_q.pop_front()});
      end
      prev_hold  = rx_if.valid && !rx_if.ready;
      prev_data  = rx_if.data;
      prev_valid = rx_if.valid;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    wait_cycles(SCALE);
  endtask

  // One 8N1 frame, LSB first; the line is left at the stop-bit level.
  task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  int         fe_base;
  int         ov_base;
  int         vh_base;
  int         fall_cycle;
  int         lat;
  bit         done;
  logic [7:0] rb;

  initial begin
    #2 arstn = 1'b0;
    rx_if.ready = 1'b1;
    wait_cycles(3);
    check_output("reset_valid", {31'd0, rx_if.valid}, 32'd0);
    check_output("reset_data", {24'd0, rx_if.data}, 32'd0);
    check_output("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check_output("reset_overrun", {31'd0, overrun}, 32'd0);
    arstn = 1'b1;
    wait_cycles(5);

    // Single frame 0xA5: data, one-cycle valid, latency from rx fall.
    vh_base    = valid_high_cnt;
    fall_cycle = cycle;
    exp_q.push_back(8'hA5);
    apply_stimulus(8'hA5, 1'b1);
    wait_cycles(10);
    lat = valid_rise_cycle - fall_cycle;
    check_output("latency_in_window", {31'd0, (lat >= 95 && lat <= 100)}, 32'd1);
    check_output("valid_one_cycle", 32'(valid_high_cnt - vh_base), 32'd1);
    check_output("a5_drained", 32'(exp_q.size()), 32'd0);

    // Start glitch of 3 clocks must be ignored, next frame still received.
    fe_base = frame_err_cnt;
    vh_base = valid_high_cnt;
    rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    wait_cycles(20);
    check_output("glitch_no_valid", 32'(valid_high_cnt - vh_base), 32'd0);
    check_output("glitch_no_frame_err", 32'(frame_err_cnt - fe_base), 32'd0);
    exp_q.push_back(8'h5A);
    apply_stimulus(8'h5A, 1'b1);
    wait_cycles(5);
    check_output("glitch_next_drained", 32'(exp_q.size()), 32'd0);

    // Bad stop bit on 0x3C with line held low, then 0x81.
    fe_base = frame_err_cnt;
    ov_base = overrun_cnt;
    vh_base = valid_high_cnt;
    apply_stimulus(8'h3C, 1'b0);
    wait_cycles(30);
    rx = 1'b1;
    wait_cycles(20);
    check_output("ferr_once", 32'(frame_err_cnt - fe_base), 32'd1);
    check_output("ferr_no_valid", 32'(valid_high_cnt - vh_base), 32'd0);
    check_output("ferr_no_overrun", 32'(overrun_cnt - ov_base), 32'd0);
    exp_q.push_back(8'h81);
    apply_stimulus(8'h81, 1'b1);
    wait_cycles(5);
    check_output("ferr_next_drained", 32'(exp_q.size()), 32'd0);

    // Overrun: ready low, 0x11 held, 0x22 dropped.
    fe_base = frame_err_cnt;
    ov_base = overrun_cnt;
    rx_if.ready = 1'b0;
    exp_q.push_back(8'h11);
    apply_stimulus(8'h11, 1'b1);
    apply_stimulus(8'h22, 1'b1);
    wait_cycles(5);
    check_output("ovr_once", 32'(overrun_cnt - ov_base), 32'd1);
    check_output("ovr_no_frame_err", 32'(frame_err_cnt - fe_base), 32'd0);
    check_output("ovr_valid_held", {31'd0, rx_if.valid}, 32'd1);
    check_output("ovr_data_held", {24'd0, rx_if.data}, 32'h11);
    rx_if.ready = 1'b1;
    wait_cycles(3);
    check_output("ovr_consumed", {31'd0, rx_if.valid}, 32'd0);
    check_output("ovr_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of 0x77 after data bit 3, then 0x5A.
    rb = 8'h77;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(rb[i]);
    arstn = 1'b0;
    rx    = 1'b1;
    wait_cycles(3);
    check_output("mid_reset_valid", {31'd0, rx_if.valid}, 32'd0);
    check_output("mid_reset_data", {24'd0, rx_if.data}, 32'd0);
    check_output("mid_reset_frame_err", {31'd0, frame_err}, 32'd0);
    check_output("mid_reset_overrun", {31'd0, overrun}, 32'd0);
    arstn = 1'b1;
    wait_cycles(20);
    vh_base = valid_high_cnt;
    exp_q.push_back(8'h5A);
    apply_stimulus(8'h5A, 1'b1);
    wait_cycles(5);
    check_output("post_reset_one_byte", 32'(valid_high_cnt - vh_base), 32'd1);
    check_output("post_reset_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back random bytes with random ready stalls.
    fe_base = frame_err_cnt;
    ov_base = overrun_cnt;
    done    = 1'b0;
    fork
      begin
        for (int n = 0; n < 16; n++) begin
          rb = 8'($urandom_range(0, 255));
          exp_q.push_back(rb);
          apply_stimulus(rb, 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          rx_if.ready = ($urandom_range(0, 99) < 50);
          wait_cycles(1);
        end
      end
    join
    rx_if.ready = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (exp_q.size() == 0) break;
      wait_cycles(1);
    end
    check_output("stream_drained", 32'(exp_q.size()), 32'd0);
    check_output("stream_no_frame_err", 32'(frame_err_cnt - fe_base), 32'd0);
    check_output("stream_no_overrun", 32'(overrun_cnt - ov_base), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
